// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 ALU.
package alu_pkg;

    localparam int unsigned MaxWidth = 64;

    // Result driven for any ALUControl code that is not a defined operation.
    localparam logic [MaxWidth-1:0] DefaultResult = '1;

    typedef enum logic [3:0] {
        OpAnd  = 4'b0000,
        OpOr   = 4'b0001,
        OpAdd  = 4'b0010,
        OpEor  = 4'b0011,
        OpLsl  = 4'b0100,
        OpLsr  = 4'b0101,
        OpSub  = 4'b0110,
        OpPass = 4'b0111,
        OpMul  = 4'b1000,
        OpAsr  = 4'b1001
    } alu_op_t;

    typedef enum logic [0:0] {
        StIdle,
        StMul
    } alu_state_t;

endpackage

// File: rtl/alu_mc_mul_iter.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// done_o is asserted for one cycle with product_o valid in that same cycle.
module mul_iter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CntW-1:0]  count_q;
    logic             busy_q;

    always_comb begin
        acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
        done_o    = busy_q && (count_q == CntW'(1));
        product_o = acc_d;
    end

    // The partial product for multiplier bit 0 is folded into the start cycle,
    // so the remaining WIDTH-1 bits finish as count reaches zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= b_i[0] ? a_i : '0;
            mcand_q  <= a_i << 1;
            mplier_q <= b_i >> 1;
            count_q  <= CntW'(WIDTH - 1);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q - 1'b1;
            if (count_q == CntW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle LEGv8 ALU: single-cycle logic/arith/shift ops plus iterative multiply,
// with registered result, NZCV flags and a valid/ready handshake.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned ShW = $clog2(WIDTH);
    localparam int unsigned Msb = WIDTH - 1;

    alu_state_t       state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             negative_q;
    logic             carry_q;
    logic             overflow_q;
    logic             out_valid_q;

    alu_op_t          op;
    logic [ShW-1:0]   shamt;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic             load;
    logic [WIDTH-1:0] fin_res;
    logic             fin_c;
    logic             fin_v;

    assign op    = alu_op_t'(ALUControl);
    assign shamt = b[ShW-1:0];

    always_comb begin
        sum_w   = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OpAnd:  alu_res = a & b;
            OpOr:   alu_res = a | b;
            OpEor:  alu_res = a ^ b;
            OpAdd: begin
                sum_w   = {1'b0, a} + {1'b0, b};
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (a[Msb] == b[Msb]) && (alu_res[Msb] != a[Msb]);
            end
            OpSub: begin
                sum_w   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (a[Msb] != b[Msb]) && (alu_res[Msb] != a[Msb]);
            end
            OpLsl:  alu_res = a << shamt;
            OpLsr:  alu_res = a >> shamt;
            OpAsr:  alu_res = $signed(a) >>> shamt;
            OpPass: alu_res = b;
            OpMul:  alu_res = '0;
            default: alu_res = DefaultResult[WIDTH-1:0];
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign mul_start = in_valid && in_ready && (op == OpMul);

    mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul_iter (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (mul_start),
        .a_i      (a),
        .b_i      (b),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

    always_comb begin
        load    = 1'b0;
        fin_res = alu_res;
        fin_c   = alu_c;
        fin_v   = alu_v;
        if (state_q == StMul) begin
            load    = mul_done;
            fin_res = mul_product;
            fin_c   = 1'b0;
            fin_v   = 1'b0;
        end else begin
            load = in_valid && (op != OpMul);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            result_q    <= '0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= load;
            if (load) begin
                result_q   <= fin_res;
                zero_q     <= (fin_res == '0);
                negative_q <= fin_res[Msb];
                carry_q    <= fin_c;
                overflow_q <= fin_v;
            end
            unique case (state_q)
                StIdle: if (mul_start) state_q <= StMul;
                StMul:  if (mul_done) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=64): directed cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int unsigned W = 64;

    typedef struct packed {
        logic [W-1:0] res;
        logic         n;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   ALUControl;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mc #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ALUControl(ALUControl),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no end of test, required end of test");
        $fatal(1, "watchdog expired");
    end

    // Reference: true arithmetic, then reduce modulo 2^64.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t                e;
        logic [W:0]          u;
        logic signed [W+1:0] t;
        logic signed [W+1:0] r;
        logic [2*W-1:0]      p;
        int                  sh;
        e  = '0;
        sh = int'(y[5:0]);
        t  = '0;
        case (op)
            4'd0: e.res = x & y;
            4'd1: e.res = x | y;
            4'd2: begin
                u     = {1'b0, x} + {1'b0, y};
                e.res = u[W-1:0];
                e.c   = (u >= (65'd1 << 64));
                t     = $signed({{2{x[W-1]}}, x}) + $signed({{2{y[W-1]}}, y});
            end
            4'd3: e.res = x ^ y;
            4'd4: e.res = x << sh;
            4'd5: e.res = x >> sh;
            4'd6: begin
                e.res = x - y;
                e.c   = (x >= y);
                t     = $signed({{2{x[W-1]}}, x}) - $signed({{2{y[W-1]}}, y});
            end
            4'd7: e.res = y;
            4'd8: begin
                p     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                e.res = p[W-1:0];
            end
            4'd9: e.res = $signed(x) >>> sh;
            default: e.res = {W{1'b1}};
        endcase
        if (op == 4'd2 || op == 4'd6) begin
            r   = $signed({{2{e.res[W-1]}}, e.res});
            e.v = (t != r);
        end
        e.n = e.res[W-1];
        e.z = (e.res == '0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_result(input string tag, input exp_t e);
        chk({tag, "/out_valid"}, W'(out_valid), W'(1));
        chk({tag, "/result"}, result, e.res);
        chk({tag, "/zncv"}, W'({zero, negative, carry, overflow}), W'({e.z, e.n, e.c, e.v}));
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input string tag);
        exp_t e;
        e = model(op, av, bv);
        @(negedge clk);
        chk({tag, "/ready"}, W'(in_ready), W'(1));
        in_valid   = 1'b1;
        ALUControl = op;
        a          = av;
        b          = bv;
        @(negedge clk);
        in_valid = 1'b0;
        if (op == 4'd8) begin
            for (int k = 1; k < 64; k++) begin
                chk({tag, "/busy"}, W'({in_ready, out_valid}), W'(0));
                @(negedge clk);
            end
            chk({tag, "/ready_back"}, W'(in_ready), W'(1));
        end
        check_result(tag, e);
    endtask

    initial begin
        exp_t        e1;
        exp_t        e2;
        exp_t        e3;
        logic [3:0]  op;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int          pulses;

        reset_n    = 1'b0;
        in_valid   = 1'b1;
        ALUControl = OpAdd;
        a          = 64'd1;
        b          = 64'd1;
        repeat (3) @(negedge clk);
        chk("reset/result", result, '0);
        chk("reset/flags_valid", W'({zero, negative, carry, overflow, out_valid}), W'(0));
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_reset/ready", W'(in_ready), W'(1));
        chk("post_reset/out_valid", W'(out_valid), W'(0));

        run_op(OpAdd, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "add_ovf");
        chk("add_ovf/const", result, 64'h8000_0000_0000_0000);
        run_op(OpSub, 64'd5, 64'd5, "sub_eq");
        run_op(OpSub, 64'd0, 64'd1, "sub_borrow");
        run_op(4'hF, 64'h1234, 64'h5678, "undef");
        chk("undef/const", result, {W{1'b1}});
        run_op(OpMul, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "mul_max");

        // MUL with an ADD held on the inputs the whole time.
        e1 = model(4'd8, 64'd3, 64'd7);
        e2 = model(4'd2, 64'd100, 64'd23);
        @(negedge clk);
        in_valid   = 1'b1;
        ALUControl = OpMul;
        a          = 64'd3;
        b          = 64'd7;
        @(negedge clk);
        ALUControl = OpAdd;
        a          = 64'd100;
        b          = 64'd23;
        for (int k = 1; k < 64; k++) begin
            chk("mul_hold/busy", W'({in_ready, out_valid}), W'(0));
            @(negedge clk);
        end
        check_result("mul_hold/mul", e1);
        chk("mul_hold/ready", W'(in_ready), W'(1));
        @(negedge clk);
        in_valid = 1'b0;
        check_result("mul_hold/add", e2);
        @(negedge clk);
        chk("mul_hold/single_pulse", W'(out_valid), W'(0));

        // Back-to-back single-cycle ops.
        e1 = model(4'd0, 64'hF0, 64'h3C);
        e2 = model(4'd4, 64'd1, 64'd63);
        e3 = model(4'd9, 64'h8000_0000_0000_0000, 64'd4);
        @(negedge clk);
        in_valid   = 1'b1;
        ALUControl = OpAnd;
        a          = 64'hF0;
        b          = 64'h3C;
        @(negedge clk);
        ALUControl = OpLsl;
        a          = 64'd1;
        b          = 64'd63;
        check_result("b2b/and", e1);
        @(negedge clk);
        ALUControl = OpAsr;
        a          = 64'h8000_0000_0000_0000;
        b          = 64'd4;
        check_result("b2b/lsl", e2);
        @(negedge clk);
        in_valid = 1'b0;
        check_result("b2b/asr", e3);
        chk("b2b/asr_const", result, 64'hF800_0000_0000_0000);

        // Reset in the middle of a multiply.
        @(negedge clk);
        in_valid   = 1'b1;
        ALUControl = OpMul;
        a          = 64'd12345;
        b          = 64'd678;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b1;
        ALUControl = OpOr;
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        chk("mid_reset/result", result, '0);
        chk("mid_reset/flags_valid", W'({zero, negative, carry, overflow, out_valid}), W'(0));
        chk("mid_reset/ready", W'(in_ready), W'(1));
        pulses = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
        end
        chk("mid_reset/no_out_valid", W'(pulses), W'(0));

        // Random operations.
        for (int i = 0; i < 250; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd8 && $urandom_range(0, 1) == 0) op = 4'd2;
            case ($urandom_range(0, 4))
                0: ra = '0;
                1: ra = {W{1'b1}};
                2: ra = 64'h8000_0000_0000_0000;
                3: ra = 64'h7FFF_FFFF_FFFF_FFFF;
                default: ra = {$urandom(), $urandom()};
            endcase
            rb = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) rb = ra;
            run_op(op, ra, rb, $sformatf("rand%0d_op%0d", i, op));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the LEGv8 datapath, the successor to the single-cycle combinational ALU. It keeps the existing ALUControl encodings and adds EOR, logical/arithmetic shifts and an iterative multiply. The result and full NZCV flags are registered, and a valid/ready handshake lets the control unit stall the pipeline while a multiply runs. It sits in the EX stage between the operand muxes and the EX/MEM register.

## Interface
- WIDTH, 64, operand/result width; power of two, 8..64
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  operands and ALUControl are valid this cycle
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; low $clog2(WIDTH) bits are the shift amount for shift ops
- ALUControl  in  4  operation select
- out_valid  out  1  one-cycle pulse: result and flags are updated
- result  out  WIDTH  registered result, held until the next out_valid
- zero, negative, carry, overflow  out  1 each  registered Z/N/C/V flags, held with result

## Operation
- ALUControl encodings:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 EOR
  - 0100 LSL
  - 0101 LSR
  - 0110 SUB
  - 0111 PASS b
  - 1000 MUL
  - 1001 ASR
  - any other code: result all ones
- Accept: an operation is accepted when in_valid && in_ready. When in_ready=0, in_valid is ignored and inputs are not sampled.
- FSM states are IDLE and MUL. in_ready = (state == IDLE).
- IDLE, non-MUL op accepted: compute combinationally, register result and flags, pulse out_valid next cycle. State stays IDLE.
- IDLE, MUL accepted: latch a and b, clear the accumulator, load count = WIDTH-1, go to MUL.
- MUL state, each cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and decrement count.
- MUL exit: when count = 0, register the low WIDTH bits of the product, pulse out_valid, return to IDLE.
- Arithmetic, all modulo 2^WIDTH:
  - SUB is a + ~b + 1.
  - ADD/SUB: C = carry out of bit WIDTH-1 (so SUB C=1 means no borrow). V = signed overflow.
  - All other ops: C=0, V=0.
- All ops: N = result[WIDTH-1]; Z = (result == 0).
- Shifts use b[$clog2(WIDTH)-1:0]; a shift of 0 passes a unchanged.

## Timing
- Non-MUL latency: 1 cycle. Accept at edge T, out_valid high in the cycle after T. Throughput is one op per cycle, back-to-back.
- MUL latency: WIDTH cycles. Accept at T, out_valid in cycle T+WIDTH. in_ready is low for cycles T+1 .. T+WIDTH-1 and high again in the out_valid cycle, so a new op may be accepted in that cycle.
- out_valid is never high for two consecutive cycles from a single MUL.
- Reset, on any edge with reset_n=0, regardless of state (including mid-MUL):
  - state = IDLE, count = 0
  - result = 0; zero, negative, carry, overflow = 0; out_valid = 0
  - an in-flight multiply is discarded with no out_valid
  - in_ready = 1 in the first cycle after reset_n rises
- in_valid during reset is ignored.

## Structure
- Package alu_pkg holds:
  - the ALUControl encodings as a 4-bit enum (alu_op_t)
  - the FSM enum (alu_state_t: IDLE, MUL)
  - the default-result constant
- Sub-module mul_iter (WIDTH parameter): shift-add datapath with start/done. alu_mc owns the handshake, the flag logic and the single-cycle ops.

## Test plan
- ADD, a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> one cycle later out_valid=1, result=0x8000_0000_0000_0000, N=1, V=1, C=0, Z=0.
- SUB, a=5, b=5 -> result=0, Z=1, C=1, V=0, N=0. SUB, a=0, b=1 -> result=all ones, C=0, N=1.
- MUL, a=3, b=7, accepted at T, in_valid held high with an ADD throughout:
  - in_ready=0 for T+1..T+63
  - out_valid only at T+64, result=21
  - the ADD is accepted at T+64; its out_valid appears at T+65
- Back-to-back, one per cycle:
  - AND 0xF0 & 0x3C -> 0x30
  - LSL 1 by 63 -> 0x8000_0000_0000_0000, N=1
  - ASR 0x8000_0000_0000_0000 by 4 -> 0xF800_0000_0000_0000
  - expect three consecutive out_valid pulses with these results
- Reset mid-MUL: MUL accepted, reset_n low at cycle 10 for 1 cycle -> no out_valid, result=0, all flags 0, in_ready=1 the cycle after release.
- ALUControl=1111 -> result=all ones, N=1, Z=0, C=0, V=0.
